// File: rtl/rcas_pkg.sv
// Shared types and helpers for the iterative ripple-carry adder/subtractor.
package rcas_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Chunk counter width; a single chunk still needs one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rcas_iter_if.sv
// Operand/result handshake bundle for rcas_iter; RCAS_FLAGS_EN adds zero/neg.
interface rcas_iter_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sel;
    logic             c_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             c_out;
    logic             ovf;
`ifdef RCAS_FLAGS_EN
    logic             zero;
    logic             neg;

    modport master (output in_valid, a, b, sel, c_in, out_ready,
                    input  in_ready, out_valid, result, c_out, ovf, zero, neg);
    modport slave  (input  in_valid, a, b, sel, c_in, out_ready,
                    output in_ready, out_valid, result, c_out, ovf, zero, neg);
`else
    modport master (output in_valid, a, b, sel, c_in, out_ready,
                    input  in_ready, out_valid, result, c_out, ovf);
    modport slave  (input  in_valid, a, b, sel, c_in, out_ready,
                    output in_ready, out_valid, result, c_out, ovf);
`endif
endinterface

// File: rtl/rcas_slice.sv
// Combinational CHUNK-bit ripple adder with optional B inversion.
module rcas_slice
    import rcas_pkg::*;
#(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             sel,
    input  logic             c_in,
    output logic [CHUNK-1:0] sum,
    output logic             c_out,
    output logic             c_msb
);
    logic [CHUNK-1:0] b_eff_s;
    logic [CHUNK:0]   carry_s;

    // Bitwise ripple; carry_s[i] is the carry into bit i.
    always_comb begin
        b_eff_s    = (sel == OP_SUB) ? ~b : b;
        carry_s    = {(CHUNK+1){1'b0}};
        sum        = {CHUNK{1'b0}};
        carry_s[0] = c_in;
        for (int i = 0; i < CHUNK; i++) begin
            sum[i]       = a[i] ^ b_eff_s[i] ^ carry_s[i];
            carry_s[i+1] = (a[i] & b_eff_s[i]) | (carry_s[i] & (a[i] ^ b_eff_s[i]));
        end
    end

    assign c_out = carry_s[CHUNK];
    assign c_msb = carry_s[CHUNK-1];

endmodule

// File: rtl/rcas_iter.sv
// Multi-cycle add/sub reusing one CHUNK-bit slice; RCAS_FLAGS_EN adds zero/neg flags.
module rcas_iter
    import rcas_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    rcas_iter_if.slave  bus
);
    localparam int            N        = WIDTH / CHUNK;
    localparam int            CW       = cnt_width(N);
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    state_t           state_r, state_nx_s;
    logic [WIDTH-1:0] a_r, b_r, work_r, result_r, res_nx_s;
    logic             sel_r, carry_r, c_out_r, ovf_r;
    logic             in_ready_r, out_valid_r, in_ready_nx_s, out_valid_nx_s;
    logic [CW-1:0]    cnt_r;
    logic [CHUNK-1:0] a_chunk_s, b_chunk_s, sum_s;
    logic             slice_co_s, slice_cm_s, last_s;
    int               idx_s;
`ifdef RCAS_FLAGS_EN
    logic             zero_r, neg_r;
`endif

    rcas_slice #(.CHUNK(CHUNK)) u_slice (
        .a     (a_chunk_s),
        .b     (b_chunk_s),
        .sel   (sel_r),
        .c_in  (carry_r),
        .sum   (sum_s),
        .c_out (slice_co_s),
        .c_msb (slice_cm_s)
    );

    // Select the active chunk and merge its sum into the working result.
    always_comb begin
        idx_s               = int'(cnt_r) * CHUNK;
        last_s              = (cnt_r == LAST_CNT);
        a_chunk_s           = a_r[idx_s +: CHUNK];
        b_chunk_s           = b_r[idx_s +: CHUNK];
        res_nx_s            = work_r;
        res_nx_s[idx_s +: CHUNK] = sum_s;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            S_IDLE:  if (bus.in_valid) state_nx_s = S_RUN;  else state_nx_s = S_IDLE;
            S_RUN:   if (last_s)       state_nx_s = S_DONE; else state_nx_s = S_RUN;
            S_DONE:  if (bus.out_ready) state_nx_s = S_IDLE; else state_nx_s = S_DONE;
            default: state_nx_s = S_IDLE;
        endcase
    end

    // FSM outputs, decoded from the next state so they can be registered.
    always_comb begin
        in_ready_nx_s  = (state_nx_s == S_IDLE);
        out_valid_nx_s = (state_nx_s == S_DONE);
    end

    // Handshake, operand, carry, counter and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            a_r         <= {WIDTH{1'b0}};
            b_r         <= {WIDTH{1'b0}};
            work_r      <= {WIDTH{1'b0}};
            result_r    <= {WIDTH{1'b0}};
            sel_r       <= OP_ADD;
            carry_r     <= 1'b0;
            c_out_r     <= 1'b0;
            ovf_r       <= 1'b0;
            cnt_r       <= {CW{1'b0}};
`ifdef RCAS_FLAGS_EN
            zero_r      <= 1'b0;
            neg_r       <= 1'b0;
`endif
        end else begin
            in_ready_r  <= in_ready_nx_s;
            out_valid_r <= out_valid_nx_s;
            case (state_r)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        a_r     <= bus.a;
                        b_r     <= bus.b;
                        sel_r   <= bus.sel;
                        carry_r <= bus.c_in;
                        cnt_r   <= {CW{1'b0}};
                    end
                end
                S_RUN: begin
                    work_r  <= res_nx_s;
                    carry_r <= slice_co_s;
                    cnt_r   <= cnt_r + CW'(1);
                    // Visible outputs update only on the DONE entry edge.
                    if (last_s) begin
                        result_r <= res_nx_s;
                        c_out_r  <= slice_co_s;
                        ovf_r    <= slice_co_s ^ slice_cm_s;
`ifdef RCAS_FLAGS_EN
                        zero_r   <= (res_nx_s == {WIDTH{1'b0}});
                        neg_r    <= res_nx_s[WIDTH-1];
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.result    = result_r;
    assign bus.c_out     = c_out_r;
    assign bus.ovf       = ovf_r;
`ifdef RCAS_FLAGS_EN
    assign bus.zero      = zero_r;
    assign bus.neg       = neg_r;
`endif

endmodule
